// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory bus arbiter.
// Imported by the arbiter top and its winner-select block.
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;
   localparam int BURST_DEF  = 4;
   localparam int STREAK_W   = 4;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DMA = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      RD0,
      RD1,
      WR0,
      WR1
   } arb_state_e;

endpackage

// File: rtl/mem_arb_select.sv
// Fixed CPU priority with a bounded CPU streak so DMA always
// makes progress; the streak only moves when a grant is taken.
module mem_arb_select
   import mem_arb_pkg::*;
#(
   parameter int CPU_BURST_MAX = BURST_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cpu_req,
   input  logic                dma_req,
   input  logic                grant,
   output logic                winner,
   output logic [STREAK_W-1:0] streak
);

   localparam logic [STREAK_W-1:0] LIMIT =
      STREAK_W'(CPU_BURST_MAX);

   logic [STREAK_W-1:0] streak_nx;
   logic                at_limit;
   logic                both;

   assign both     = cpu_req & dma_req;
   assign at_limit = (streak >= LIMIT);

   // Pick the winner and the streak value that the grant would leave.
   always_comb begin
      winner    = OWN_CPU;
      streak_nx = streak;
      unique case (1'b1)
         (both & at_limit): begin
            winner    = OWN_DMA;
            streak_nx = '0;
         end
         (both & ~at_limit): begin
            winner    = OWN_CPU;
            streak_nx = streak + 1'b1;
         end
         (dma_req & ~cpu_req): begin
            winner    = OWN_DMA;
            streak_nx = '0;
         end
         (cpu_req & ~dma_req): begin
            winner    = OWN_CPU;
            streak_nx = '0;
         end
         default: begin
            winner    = OWN_CPU;
            streak_nx = streak;
         end
      endcase
   end

   // Commit the streak only when the parent actually grants.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         streak <= '0;
      end else if (grant) begin
         streak <= streak_nx;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port front end for the single-port data memory:
// serialises CPU and DMA accesses with setup-then-pulse writes.
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W        = ADDR_W_DEF,
   parameter int DATA_W        = DATA_W_DEF,
   parameter int CPU_BURST_MAX = BURST_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_ack,
   output logic [DATA_W-1:0] dma_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              owner
);

   arb_state_e state;
   arb_state_e state_nx;

   logic                grant;
   logic                winner;
   logic [STREAK_W-1:0] streak;

   logic                win_we;
   logic [ADDR_W-1:0]   win_addr;
   logic [DATA_W-1:0]   win_wdata;

   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                owner_q;
   logic [DATA_W-1:0]   cpu_rdata_q;
   logic [DATA_W-1:0]   dma_rdata_q;
   logic                done;
   logic                rd_done;

   assign grant = (state == IDLE) & (cpu_req | dma_req);

   mem_arb_select #(
      .CPU_BURST_MAX (CPU_BURST_MAX)
   ) u_select (
      .clk     (clk),
      .reset   (reset),
      .cpu_req (cpu_req),
      .dma_req (dma_req),
      .grant   (grant),
      .winner  (winner),
      .streak  (streak)
   );

   // Route the winning requester's transaction fields.
   always_comb begin
      win_we    = cpu_we;
      win_addr  = cpu_addr;
      win_wdata = cpu_wdata;
      if (winner == OWN_DMA) begin
         win_we    = dma_we;
         win_addr  = dma_addr;
         win_wdata = dma_wdata;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state: one state per cycle, decision only in IDLE.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (grant) begin
               state_nx = win_we ? WR0 : RD0;
            end
         end
         RD0:     state_nx = RD1;
         RD1:     state_nx = IDLE;
         WR0:     state_nx = WR1;
         WR1:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Latch the granted transaction; these drive the memory bus.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q  <= '0;
         wdata_q <= '0;
         owner_q <= OWN_CPU;
      end else if (grant) begin
         addr_q  <= win_addr;
         wdata_q <= win_wdata;
         owner_q <= winner;
      end
   end

   // Hold read data per requester; only the owner's copy moves.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else if (rd_done) begin
         if (owner_q == OWN_CPU) begin
            cpu_rdata_q <= mem_rdata;
         end else begin
            dma_rdata_q <= mem_rdata;
         end
      end
   end

   // Acks, strobe and status decoded from state and owner.
   always_comb begin
      done      = (state == RD1) | (state == WR1);
      rd_done   = (state == RD1);
      mem_write = (state == WR1);
      busy      = (state != IDLE);
      cpu_ack   = done & (owner_q == OWN_CPU);
      dma_ack   = done & (owner_q == OWN_DMA);
      cpu_rdata = cpu_rdata_q;
      dma_rdata = dma_rdata_q;
      if (rd_done & (owner_q == OWN_CPU)) begin
         cpu_rdata = mem_rdata;
      end
      if (rd_done & (owner_q == OWN_DMA)) begin
         dma_rdata = mem_rdata;
      end
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign owner     = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a small synchronous
// memory model; inputs change and outputs are sampled on negedge.
module tb_mem_bus_arbiter;

   logic       clk;
   logic       reset;
   logic       cpu_req;
   logic       cpu_we;
   logic [7:0] cpu_addr;
   logic [7:0] cpu_wdata;
   logic       cpu_ack;
   logic [7:0] cpu_rdata;
   logic       dma_req;
   logic       dma_we;
   logic [7:0] dma_addr;
   logic [7:0] dma_wdata;
   logic       dma_ack;
   logic [7:0] dma_rdata;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_write;
   logic [7:0] mem_rdata;
   logic       busy;
   logic       owner;

   logic [7:0] mem [256];

   int total;
   int bad;

   mem_bus_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_ack   (cpu_ack),
      .cpu_rdata (cpu_rdata),
      .dma_req   (dma_req),
      .dma_we    (dma_we),
      .dma_addr  (dma_addr),
      .dma_wdata (dma_wdata),
      .dma_ack   (dma_ack),
      .dma_rdata (dma_rdata),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_write (mem_write),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .owner     (owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port memory, one-cycle read latency.
   always @(posedge clk) begin
      if (mem_write) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   logic [6:0] order;
   int         ack_i;

   initial begin
      total = 0;
      bad   = 0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h10] = 8'hA5;
      mem[8'h05] = 8'h55;
      mem[8'h06] = 8'h66;
      mem[8'h30] = 8'h11;
      mem_rdata = 8'h00;
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
      reset = 1'b1;
      #2 reset = 1'b0;
      step();
      check("rst_busy", busy, 0);
      check("rst_ack", {cpu_ack, dma_ack}, 0);
      check("rst_mwr", mem_write, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_wdata", mem_wdata, 0);
      check("rst_rdata", {cpu_rdata, dma_rdata}, 0);
      check("rst_owner", owner, 0);
      reset = 1'b1;

      // reset mid-write
      dma_req = 1; dma_we = 1; dma_addr = 8'h30; dma_wdata = 8'h77;
      step();
      check("t1_wr0_mwr", mem_write, 0);
      check("t1_wr0_addr", mem_addr, 8'h30);
      check("t1_wr0_own", owner, 1);
      reset = 1'b0;
      #1;
      check("t1_async_busy", busy, 0);
      check("t1_async_addr", mem_addr, 0);
      check("t1_async_wd", mem_wdata, 0);
      check("t1_async_own", owner, 0);
      dma_req = 0;
      step();
      check("t1_mwr", mem_write, 0);
      check("t1_ack", {cpu_ack, dma_ack}, 0);
      reset = 1'b1;
      step();
      check("t1_ack2", {cpu_ack, dma_ack}, 0);
      check("t1_mem", mem[8'h30], 8'h11);

      // CPU read after reset
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
      step();
      check("t2_rd0_addr", mem_addr, 8'h10);
      check("t2_rd0_ack", cpu_ack, 0);
      check("t2_rd0_mwr", mem_write, 0);
      step();
      check("t2_ack", cpu_ack, 1);
      check("t2_rdata", cpu_rdata, 8'hA5);
      check("t2_mwr", mem_write, 0);
      check("t2_dack", dma_ack, 0);
      cpu_req = 0;
      step();
      check("t2_idle", busy, 0);
      check("t2_hold", cpu_rdata, 8'hA5);

      // DMA write then DMA read back
      dma_req = 1; dma_we = 1; dma_addr = 8'h20; dma_wdata = 8'h3C;
      step();
      check("t3_wr0_addr", mem_addr, 8'h20);
      check("t3_wr0_wd", mem_wdata, 8'h3C);
      check("t3_wr0_mwr", mem_write, 0);
      check("t3_wr0_ack", dma_ack, 0);
      step();
      check("t3_wr1_mwr", mem_write, 1);
      check("t3_wr1_ack", dma_ack, 1);
      check("t3_wr1_cack", cpu_ack, 0);
      dma_req = 0;
      step();
      check("t3_mwr_off", mem_write, 0);
      check("t3_mem", mem[8'h20], 8'h3C);
      dma_req = 1; dma_we = 0;
      step();
      step();
      check("t3_rb_ack", dma_ack, 1);
      check("t3_rb_data", dma_rdata, 8'h3C);
      check("t3_cpu_hold", cpu_rdata, 8'hA5);
      dma_req = 0;
      step();

      // address wrap on a CPU write
      cpu_req = 1; cpu_we = 1; cpu_addr = 8'hFF; cpu_wdata = 8'h5A;
      step();
      check("wrap_addr", mem_addr, 8'hFF);
      step();
      check("wrap_ack", cpu_ack, 1);
      cpu_req = 0;
      step();
      check("wrap_mem", mem[8'hFF], 8'h5A);

      // inputs changed mid-transaction
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h05;
      step();
      check("t5_rd0_addr", mem_addr, 8'h05);
      cpu_addr = 8'h06;
      cpu_req = 0;
      step();
      check("t5_ack", cpu_ack, 1);
      check("t5_addr", mem_addr, 8'h05);
      check("t5_data", cpu_rdata, 8'h55);
      step();
      check("t5_idle", busy, 0);
      step();
      check("t5_no_more", {busy, cpu_ack}, 0);

      // simultaneous first request after reset
      reset = 1'b0;
      step();
      reset = 1'b1;
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
      dma_req = 1; dma_we = 0; dma_addr = 8'h05;
      step();
      check("t6_owner_c", owner, 0);
      step();
      check("t6_cack", cpu_ack, 1);
      check("t6_dack", dma_ack, 0);
      check("t6_drd", dma_rdata, 0);
      check("t6_crd", cpu_rdata, 8'hA5);
      cpu_req = 0;
      step();
      check("t6_idle", busy, 0);
      step();
      check("t6_owner_d", owner, 1);
      step();
      check("t6_dack2", dma_ack, 1);
      check("t6_drd2", dma_rdata, 8'h55);
      check("t6_crd2", cpu_rdata, 8'hA5);
      dma_req = 0;
      step();

      // starvation limit: both held high
      order = 7'b0010000;
      ack_i = 0;
      cpu_req = 1; cpu_addr = 8'h10;
      dma_req = 1; dma_addr = 8'h05;
      for (int k = 1; k <= 21; k++) begin
         step();
         check("t4_mwr", mem_write, 0);
         if (k % 3 == 2) begin
            check("t4_cack", cpu_ack, !order[ack_i]);
            check("t4_dack", dma_ack, order[ack_i]);
            ack_i++;
         end else begin
            check("t4_noack", {cpu_ack, dma_ack}, 0);
         end
      end
      cpu_req = 0;
      dma_req = 0;
      step();
      check("t4_done", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
